fifo_ptr_ctrl: RTL and testbench
================================

# fifo_ptr_ctrl

Parametrised read/write pointer controller for the lab FIFO datapath: the next generation of the single read-pointer register. It owns both pointers, an occupancy count, and registered full/empty/almost flags. It supports any depth up to 2^ADDR_W, including non-power-of-two depths, and has a synchronous flush. It sits between the producer/consumer request logic and the dual-port FIFO RAM, driving its write/read addresses and enables.

## Interface
- ADDR_W, 8, pointer width in bits
- DEPTH, 256, number of entries; 2 ≤ DEPTH ≤ 2^ADDR_W
- AFULL_TH, DEPTH-2, almost_full asserted when count ≥ AFULL_TH; 0 < AFULL_TH ≤ DEPTH
- AEMPTY_TH, 1, almost_empty asserted when count ≤ AEMPTY_TH; AEMPTY_TH < DEPTH
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous flush
- wr_req  in  1  producer write request
- rd_req  in  1  consumer read request
- wr_ack  out  1  write accepted this cycle; combinational; doubles as RAM write enable
- rd_ack  out  1  read accepted this cycle; combinational
- wp  out  ADDR_W  current write address, registered
- rp  out  ADDR_W  current read address, registered
- count  out  ADDR_W+1  occupancy 0..DEPTH, registered
- full, empty, almost_full, almost_empty  out  1 each  registered flags
- overflow, underflow  out  1 each  one-cycle pulse: a request was rejected in the previous cycle

## Operation
- Write acceptance: wr_ack = wr_req & ~full & ~clr.
- Read acceptance: rd_ack = rd_req & ~empty & ~clr.
- Both acks use the registered flags only. No same-cycle bypass:
  - Full, both requested: the read is accepted and the write is rejected.
  - Empty, both requested: the write is accepted and the read is rejected.
- Accepted write: wp advances by 1. Accepted read: rp advances by 1.
- Wrap rule: a pointer at DEPTH-1 returns to 0. This holds for both pointers and for non-power-of-two DEPTH. A pointer never holds a value ≥ DEPTH.
- Count update:
  - count +1 on write-only acceptance.
  - count -1 on read-only acceptance.
  - count unchanged when both are accepted or neither is.
  - count never leaves 0..DEPTH.
- Flag decode, from the next count so flags are valid on the same edge as count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AFULL_TH)
  - almost_empty = (count ≤ AEMPTY_TH)
- Rejection pulses: overflow is registered from wr_req & full. underflow is registered from rd_req & empty. Requests masked by clr do not raise either pulse.
- clr has priority over everything. At the next edge: wp = rp = 0, count = 0, flags return to their reset values, and no ack is issued.
- Reset (rst high, asynchronous) drives:
  - wp = 0, rp = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = 0, underflow = 0
- Reset released mid-operation: the first edge after deassertion behaves as a normal cycle from the empty state. Queued requests are not remembered.

## Timing
- Ack latency: 0 cycles, same cycle as the request.
- Pointer, count and flag latency: updated on the rising edge that ends the ack cycle, i.e. visible one cycle after the ack.
- Pulse latency: overflow/underflow go high one cycle after the rejected request, for exactly one cycle per rejected cycle.
- Back-to-back: one write and one read can be accepted per cycle, sustained.
- Flag exits: full deasserts the cycle after the first read from full. empty deasserts the cycle after the first write into empty.
- No combinational path from wr_req to rd_ack or from rd_req to wr_ack.

## Structure
- Shared package fifo_pkg:
  - default ADDR_W and DEPTH constants
  - wrap-increment function (ptr, DEPTH)
  - threshold sanity-check constants, shared with the FIFO RAM wrapper
- Sub-module fifo_ptr_reg: enable-gated wrapping pointer register with clk, rst, clr, en and ptr. It is instantiated twice, once for the write pointer and once for the read pointer.
- Count, flags and pulses live in fifo_ptr_ctrl.

## Test plan
- Reset with wr_req/rd_req held high -> wp=rp=0, count=0, empty=1, almost_empty=1, no acks while rst is high.
- DEPTH=6, ADDR_W=3: 6 writes then 1 more -> wp sequence 1..5,0; full=1 after the 6th write; 7th write gives wr_ack=0 and an overflow pulse one cycle later.
- DEPTH=6, from full: 6 reads -> rp wraps 5→0; empty=1 after the 6th read; 7th read gives underflow; count 6→0.
- Simultaneous wr_req and rd_req at count=3 for 4 cycles -> both acked every cycle, count stays 3, wp and rp each advance by 4 modulo 6.
- Simultaneous requests at full and at empty -> only the read is accepted at full; only the write is accepted at empty; no overflow or underflow pulse for the accepted side.
- clr asserted at count=4 with wr_req=1 -> no ack; next edge wp=rp=0, count=0, empty=1; no overflow pulse. Also, rst pulsed asynchronously between edges at count=5 -> outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default geometry, wrap-increment helper and parameter sanity checks.
// Also used by the FIFO RAM wrapper, so keep it free of module-specific logic.
package fifo_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

    localparam int MIN_DEPTH  = 2;
    localparam int MAX_ADDR_W = 30;

    // Increment that returns to 0 after depth-1, so non-power-of-two depths work.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] nxt;
        nxt = (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
        return nxt;
    endfunction

    function automatic bit cfg_ok(input int addr_w, input int depth,
                                  input int afull_th, input int aempty_th);
        bit ok;
        ok = (addr_w >= 1) && (addr_w <= MAX_ADDR_W)
          && (depth >= MIN_DEPTH) && (depth <= (1 << addr_w))
          && (afull_th > 0) && (afull_th <= depth)
          && (aempty_th >= 0) && (aempty_th < depth);
        return ok;
    endfunction

endpackage

// File: rtl/fifo_ptr_reg.sv
// Enable-gated wrapping pointer register: advances one slot per enabled edge, 0..DEPTH-1.
// No backpressure of its own; the caller decides when en may be asserted.
module fifo_ptr_reg
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ADDR_W'(wrap_inc(32'(ptr), 32'(DEPTH)));
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO read/write pointer controller: acks are combinational, pointers/count/flags update on the ack edge.
// Writes are refused while full and reads while empty; rejections raise a one-cycle overflow/underflow pulse.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic [ADDR_W-1:0] wp,
    output logic [ADDR_W-1:0] rp,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] ONE_C    = (ADDR_W + 1)'(1);

    if (!cfg_ok(ADDR_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
        $error("fifo_ptr_ctrl: inconsistent ADDR_W/DEPTH/threshold parameters");
    end

    logic [ADDR_W:0] count_nxt;

    // Acks look only at registered flags so neither request can reach the other ack.
    // rst also blocks acks so nothing is written to the RAM while in reset.
    assign wr_ack = wr_req & ~full  & ~clr & ~rst;
    assign rd_ack = rd_req & ~empty & ~clr & ~rst;

    fifo_ptr_reg #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (wr_ack),
        .ptr    (wp)
    );

    fifo_ptr_reg #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (rd_ack),
        .ptr    (rp)
    );

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (wr_ack && !rd_ack) begin
            count_nxt = count + ONE_C;
        end else if (rd_ack && !wr_ack) begin
            count_nxt = count - ONE_C;
        end
    end

    // Flags decode the next count so they land on the same edge as count itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AFULL_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            overflow     <= wr_req & full  & ~clr;
            underflow    <= rd_req & empty & ~clr;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl at DEPTH=6: directed fill/drain/clr/reset cases plus random traffic.
module tb_fifo_ptr_ctrl;

    localparam int AW = 3;
    localparam int D  = 6;
    localparam int AF = 4;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst, clr, wr_req, rd_req;
    logic          wr_ack, rd_ack;
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ptr_ctrl #(
        .ADDR_W    (AW),
        .DEPTH     (D),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .wp           (wp),
        .rp           (rp),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wp, rp, cnt;
        bit full, empty, af, ae, ov, un;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    int m_wp, m_rp, m_cnt;
    bit m_full, m_empty, m_af, m_ae, m_ov, m_un;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_flags();
        m_full  = (m_cnt == D);
        m_empty = (m_cnt == 0);
        m_af    = (m_cnt >= AF);
        m_ae    = (m_cnt <= AE);
    endtask

    task automatic model_reset();
        m_wp = 0; m_rp = 0; m_cnt = 0; m_ov = 0; m_un = 0;
        model_flags();
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.wp = m_wp; e.rp = m_rp; e.cnt = m_cnt;
        e.full = m_full; e.empty = m_empty; e.af = m_af; e.ae = m_ae;
        e.ov = m_ov; e.un = m_un;
        return e;
    endfunction

    task automatic check_regs(input exp_t e);
        chk("wp",           int'(wp),           e.wp);
        chk("rp",           int'(rp),           e.rp);
        chk("count",        int'(count),        e.cnt);
        chk("full",         int'(full),         int'(e.full));
        chk("empty",        int'(empty),        int'(e.empty));
        chk("almost_full",  int'(almost_full),  int'(e.af));
        chk("almost_empty", int'(almost_empty), int'(e.ae));
        chk("overflow",     int'(overflow),     int'(e.ov));
        chk("underflow",    int'(underflow),    int'(e.un));
    endtask

    // One clock of stimulus: acks checked in-cycle, registered outputs checked after the edge.
    task automatic cycle(input bit w, input bit r, input bit c);
        bit   ew, er;
        exp_t e;
        @(negedge clk);
        wr_req = w; rd_req = r; clr = c;
        #1;
        ew = w && !m_full && !c;
        er = r && !m_empty && !c;
        chk("wr_ack", int'(wr_ack), int'(ew));
        chk("rd_ack", int'(rd_ack), int'(er));
        if (c) begin
            m_wp = 0; m_rp = 0; m_cnt = 0; m_ov = 0; m_un = 0;
        end else begin
            m_ov = w && m_full;
            m_un = r && m_empty;
            if (ew) m_wp = (m_wp + 1) % D;
            if (er) m_rp = (m_rp + 1) % D;
            m_cnt = m_cnt + int'(ew) - int'(er);
        end
        model_flags();
        q.push_back(snap());
        @(posedge clk);
        #1;
        chk("sb_depth", q.size(), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check_regs(e);
        end
    endtask

    initial begin
        bit rw, rr, rc;
        rst = 1'b1; clr = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
        model_reset();

        // Requests held high during reset must not be acked.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_rd_ack", int'(rd_ack), 0);
        check_regs(snap());
        @(negedge clk);
        rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;

        // Fill to full, then one rejected write and the resulting pulse.
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Both requested at full: only the read goes through.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Drain through the read-pointer wrap, then one rejected read.
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Both requested at empty: only the write goes through.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Sustained simultaneous traffic at count=3.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);

        // Flush at count=4 with a write pending, then at empty with a read pending.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset pulse between edges at count=5.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        wr_req = 1'b1; rd_req = 1'b0; clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_wr_ack", int'(wr_ack), 0);
        check_regs(snap());
        #1 rst = 1'b0;
        wr_req = 1'b0;

        for (int i = 0; i < 80; i++) begin
            rw = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 11) == 0);
            cycle(rw, rr, rc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
